data_mem: RTL and testbench

Single-port synchronous data memory that sits directly downstream of the load and store units in the RISC-V datapath. It accepts one word-aligned access per request, commits writes with byte strobes, and returns the full aligned 32-bit word for reads. Byte and halfword extraction and sign extension stay in the load unit. A programmable wait-state counter models slow memory; the memory asserts busy while it stalls.

---
 rtl/data_mem_pkg.sv | 22 ++
 rtl/data_mem_array.sv | 52 +++++
 rtl/data_mem.sv | 145 ++++++++++++++
 tb/tb_data_mem.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared definitions for the data memory
// Purpose: mem_size encodings, data memory FSM state type and a
//          misalignment helper used by data_mem.
// Ports: none (package).
package data_mem_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

  // Half needs addr[0]=0; word and the reserved 11 encoding need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == MEM_SIZE_H) && lo[0]) || (size[1] && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// rtl/data_mem_array.sv - word storage with byte write enables and registered read
// Purpose: DEPTH_WORDS x 32 storage (contents never cleared), plus a read
//          data register that is cleared by reset.
// Ports:
//   i_clk            clock
//   i_rst            synchronous active-high reset (read register only)
//   i_we, i_wstrb    write enable and per-lane byte enables
//   i_waddr, i_wdata write word index and lane-aligned data
//   i_re             load the read register
//   i_rzero          load zero instead of the array word (suppressed read)
//   i_raddr          read word index
//   o_rdata          registered read data, held until the next i_re
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [3:0]       i_wstrb,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [31:0]      i_wdata,
  input  logic             i_re,
  input  logic             i_rzero,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= 32'h0;
    end else if (i_re) begin
      r_rdata <= i_rzero ? 32'h0 : r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem.sv
// rtl/data_mem.sv - single-port data memory with programmable wait states
// Purpose: word-aligned load/store target. Writes commit with byte strobes at
//          the accepting edge; reads return the full aligned word. Out-of-range
//          accesses are suppressed and flagged with mem_err.
// Optional feature: define DMEM_MISALIGN_CHECK_EN to also suppress and flag
//          misaligned half/word accesses.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   mem_req          request strobe (ignored while mem_busy)
//   mem_rw_mode      1 = read, 0 = write
//   mem_addr         byte address
//   mem_size         00 byte, 01 half, 10/11 word
//   mem_wdata        lane-aligned write data
//   mem_wstrb        byte lane write enables
//   mem_data         registered read data, held across write responses
//   mem_ack          one-cycle completion pulse
//   mem_err          completion of a suppressed access
//   mem_busy         high while stalling in WAIT
module data_mem
  import data_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        mem_req,
  input  logic        mem_rw_mode,
  input  logic [31:0] mem_addr,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_data,
  output logic        mem_ack,
  output logic        mem_err,
  output logic        mem_busy
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [2:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  dmem_state_e      r_state;
  dmem_state_e      w_next;
  logic [2:0]       r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_rw;
  logic             r_err;

  logic [29:0]      w_word;
  logic             w_oor;
  logic             w_mis;
  logic             w_err;
  logic             w_acc;
  logic             w_we;
  logic             w_re;
  logic             w_rzero;
  logic [IDX_W-1:0] w_raddr;

  // Offset wraps modulo 2^32, so addresses below ADDR_BASE land far out of range.
  assign w_word = 30'((mem_addr - ADDR_BASE) >> 2);
  assign w_oor  = ({2'b00, w_word} >= 32'(DEPTH_WORDS));

`ifdef DMEM_MISALIGN_CHECK_EN
  assign w_mis = is_misaligned(mem_size, mem_addr[1:0]);
`else
  // Size is irrelevant here; the AND keeps the port referenced.
  assign w_mis = 1'b0 & (^mem_size);
`endif

  assign w_err = w_oor | w_mis;

  // Accepted in IDLE or RESP; reset in the same cycle discards the request.
  assign w_acc = !i_rst && mem_req && (r_state != DMEM_WAIT);
  assign w_we  = w_acc && !mem_rw_mode && !w_err;

  // The read register loads on the edge entering RESP: the accepting edge when
  // there are no wait states, otherwise the last WAIT edge using captured fields.
  assign w_re    = (WAIT_CYCLES == 0) ? (w_acc && mem_rw_mode)
                                      : ((r_state == DMEM_WAIT) && (r_cnt == 3'd0) && r_rw);
  assign w_rzero = (WAIT_CYCLES == 0) ? w_err : r_err;
  assign w_raddr = (WAIT_CYCLES == 0) ? w_word[IDX_W-1:0] : r_idx;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_we   (w_we),
    .i_wstrb(mem_wstrb),
    .i_waddr(w_word[IDX_W-1:0]),
    .i_wdata(mem_wdata),
    .i_re   (w_re),
    .i_rzero(w_rzero),
    .i_raddr(w_raddr),
    .o_rdata(mem_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= DMEM_IDLE;
      r_cnt   <= 3'd0;
      r_idx   <= '0;
      r_rw    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_idx <= w_word[IDX_W-1:0];
        r_rw  <= mem_rw_mode;
        r_err <= w_err;
        r_cnt <= WAIT_LOAD;
      end else if ((r_state == DMEM_WAIT) && (r_cnt != 3'd0)) begin
        r_cnt <= r_cnt - 3'd1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      DMEM_IDLE, DMEM_RESP: begin
        if (mem_req) begin
          w_next = (WAIT_CYCLES > 0) ? DMEM_WAIT : DMEM_RESP;
        end else begin
          w_next = DMEM_IDLE;
        end
      end
      DMEM_WAIT: begin
        if (r_cnt == 3'd0) begin
          w_next = DMEM_RESP;
        end
      end
      default: w_next = DMEM_IDLE;
    endcase
  end

  always_comb begin
    mem_ack  = (r_state == DMEM_RESP);
    mem_err  = (r_state == DMEM_RESP) && r_err;
    mem_busy = (r_state == DMEM_WAIT);
  end

endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - self-checking bench for data_mem (no-wait and 3-wait instances)
module tb_data_mem;
  import data_mem_pkg::*;

  localparam int          DEPTH = 64;
  localparam int          IW    = 6;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_1000;
  localparam int          WAIT0 = 0;
  localparam int          WAIT1 = 3;
`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req   [2];
  logic        rw    [2];
  logic [31:0] addr  [2];
  logic [1:0]  size  [2];
  logic [31:0] wdata [2];
  logic [3:0]  wstrb [2];
  logic [31:0] rdata [2];
  logic        ack   [2];
  logic        err   [2];
  logic        busy  [2];

  data_mem #(.DEPTH_WORDS(DEPTH), .ADDR_BASE(BASE0), .WAIT_CYCLES(WAIT0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .mem_req(req[0]), .mem_rw_mode(rw[0]), .mem_addr(addr[0]),
    .mem_size(size[0]), .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]), .mem_data(rdata[0]),
    .mem_ack(ack[0]), .mem_err(err[0]), .mem_busy(busy[0]));

  data_mem #(.DEPTH_WORDS(DEPTH), .ADDR_BASE(BASE1), .WAIT_CYCLES(WAIT1)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .mem_req(req[1]), .mem_rw_mode(rw[1]), .mem_addr(addr[1]),
    .mem_size(size[1]), .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]), .mem_data(rdata[1]),
    .mem_ack(ack[1]), .mem_err(err[1]), .mem_busy(busy[1]));

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model   [2][DEPTH];
  logic [31:0] last_rd [2];

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? BASE0 : BASE1;
  endfunction

  function automatic int wait_of(input int d);
    return (d == 0) ? WAIT0 : WAIT1;
  endfunction

  // Reference: word index from byte offset, range/alignment rules, byte-lane merge.
  function automatic void m_access(input int d, input logic r, input logic [31:0] a,
                                   input logic [1:0] sz, input logic [31:0] wd,
                                   input logic [3:0] ws, output logic e,
                                   output logic [31:0] rd);
    logic [31:0] off;
    int unsigned idx;
    logic        mis_raw;
    off = a - base_of(d);
    idx = off / 4;
    if (sz == MEM_SIZE_B)      mis_raw = 1'b0;
    else if (sz == MEM_SIZE_H) mis_raw = (a % 2) != 0;
    else                       mis_raw = (a % 4) != 0;
    e  = (idx >= DEPTH) || (CHK && mis_raw);
    rd = last_rd[d];
    if (r) begin
      rd = e ? 32'h0 : model[d][idx[IW-1:0]];
      last_rd[d] = rd;
    end else if (!e) begin
      for (int b = 0; b < 4; b++)
        if (ws[b]) model[d][idx[IW-1:0]][8*b +: 8] = wd[8*b +: 8];
    end
  endfunction

  // Called at a negedge with the DUT in IDLE or RESP; returns at the negedge of the ack cycle.
  task automatic do_access(input int d, input logic r, input logic [31:0] a,
                           input logic [1:0] sz, input logic [31:0] wd, input logic [3:0] ws,
                           output int lat, output logic [31:0] rd, output logic e);
    req[d] = 1'b1; rw[d] = r; addr[d] = a; size[d] = sz; wdata[d] = wd; wstrb[d] = ws;
    lat = -1; rd = 32'h0; e = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge clk);
      if (c == 1) req[d] = 1'b0;
      if (ack[d]) begin
        lat = c; rd = rdata[d]; e = err[d];
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_tests++; if (ack[d] !== 1'b0) begin n_fail++; $display("FAIL reset_ack d=%0d got %b exp 0", d, ack[d]); end
      n_tests++; if (err[d] !== 1'b0) begin n_fail++; $display("FAIL reset_err d=%0d got %b exp 0", d, err[d]); end
      n_tests++; if (busy[d] !== 1'b0) begin n_fail++; $display("FAIL reset_busy d=%0d got %b exp 0", d, busy[d]); end
      n_tests++; if (rdata[d] !== 32'h0) begin n_fail++; $display("FAIL reset_data d=%0d got %h exp 0", d, rdata[d]); end
      last_rd[d] = 32'h0;
    end
    rst = 1'b0;
  endtask

  task automatic test_init();
    int lat; logic [31:0] rd, exp_rd, wd; logic e, exp_e;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < DEPTH; i++) begin
        wd = $urandom;
        m_access(d, 1'b0, base_of(d) + 32'(4*i), MEM_SIZE_W, wd, 4'hF, exp_e, exp_rd);
        do_access(d, 1'b0, base_of(d) + 32'(4*i), MEM_SIZE_W, wd, 4'hF, lat, rd, e);
        n_tests++; if (e !== exp_e || lat != 1 + wait_of(d)) begin n_fail++; $display("FAIL init_write d=%0d i=%0d err %b lat %0d exp err %b lat %0d", d, i, e, lat, exp_e, 1 + wait_of(d)); end
      end
    end
  endtask

  task automatic test_basic();
    int lat; logic [31:0] rd, exp_rd; logic e, exp_e;
    for (int d = 0; d < 2; d++) begin
      m_access(d, 1'b0, base_of(d) + 32'h10, MEM_SIZE_W, 32'hDEADBEEF, 4'hF, exp_e, exp_rd);
      do_access(d, 1'b0, base_of(d) + 32'h10, MEM_SIZE_W, 32'hDEADBEEF, 4'hF, lat, rd, e);
      m_access(d, 1'b1, base_of(d) + 32'h10, MEM_SIZE_W, 32'h0, 4'h0, exp_e, exp_rd);
      do_access(d, 1'b1, base_of(d) + 32'h10, MEM_SIZE_W, 32'h0, 4'h0, lat, rd, e);
      n_tests++; if (lat != 1 + wait_of(d)) begin n_fail++; $display("FAIL basic_lat d=%0d got %0d exp %0d", d, lat, 1 + wait_of(d)); end
      n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_read d=%0d got %h exp deadbeef", d, rd); end
      n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL basic_err d=%0d got %b exp 0", d, e); end
      m_access(d, 1'b0, base_of(d) + 32'h10, MEM_SIZE_B, 32'h0000AA00, 4'b0010, exp_e, exp_rd);
      do_access(d, 1'b0, base_of(d) + 32'h10, MEM_SIZE_B, 32'h0000AA00, 4'b0010, lat, rd, e);
      n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hold_on_write d=%0d got %h exp deadbeef", d, rd); end
      m_access(d, 1'b1, base_of(d) + 32'h10, MEM_SIZE_W, 32'h0, 4'h0, exp_e, exp_rd);
      do_access(d, 1'b1, base_of(d) + 32'h10, MEM_SIZE_W, 32'h0, 4'h0, lat, rd, e);
      n_tests++; if (rd !== 32'hDEADAAEF) begin n_fail++; $display("FAIL strobe_read d=%0d got %h exp deadaaef", d, rd); end
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd, exp_rd, a, wd; logic e, exp_e, r; logic [1:0] sz; logic [3:0] ws;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 150; k++) begin
        r  = 1'($urandom_range(0, 1));
        a  = base_of(d) + 32'(4 * $urandom_range(0, DEPTH + 7)) + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) a = $urandom;
        sz = 2'($urandom_range(0, 3));
        wd = $urandom;
        ws = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        m_access(d, r, a, sz, wd, ws, exp_e, exp_rd);
        do_access(d, r, a, sz, wd, ws, lat, rd, e);
        n_tests++; if (lat != 1 + wait_of(d)) begin n_fail++; $display("FAIL rand_lat d=%0d k=%0d got %0d exp %0d", d, k, lat, 1 + wait_of(d)); end
        n_tests++; if (e !== exp_e) begin n_fail++; $display("FAIL rand_err d=%0d k=%0d addr %h got %b exp %b", d, k, a, e, exp_e); end
        n_tests++; if (rd !== exp_rd) begin n_fail++; $display("FAIL rand_data d=%0d k=%0d rw %b addr %h got %h exp %h", d, k, r, a, rd, exp_rd); end
      end
    end
  endtask

  task automatic test_wait_busy();
    int nack, ack_at; logic [31:0] got, exp_rd; logic exp_e;
    nack = 0; ack_at = -1; got = 32'h0;
    m_access(1, 1'b1, BASE1 + 32'h10, MEM_SIZE_W, 32'h0, 4'h0, exp_e, exp_rd);
    req[1] = 1'b1; rw[1] = 1'b1; addr[1] = BASE1 + 32'h10; size[1] = MEM_SIZE_W;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      n_tests++; if (busy[1] !== 1'(c <= 3)) begin n_fail++; $display("FAIL wait_busy c=%0d got %b exp %b", c, busy[1], 1'(c <= 3)); end
      if (ack[1]) begin nack++; ack_at = c; got = rdata[1]; end
      if (c == 1) req[1] = 1'b0;
      if (c == 2) begin req[1] = 1'b1; addr[1] = BASE1 + 32'h14; end
      if (c == 3) req[1] = 1'b0;
    end
    n_tests++; if (nack != 1) begin n_fail++; $display("FAIL wait_ack_count got %0d exp 1", nack); end
    n_tests++; if (ack_at != 4) begin n_fail++; $display("FAIL wait_ack_cycle got %0d exp 4", ack_at); end
    n_tests++; if (got !== exp_rd) begin n_fail++; $display("FAIL wait_data got %h exp %h", got, exp_rd); end
  endtask

  task automatic test_back_to_back();
    int nack, a1, a2, set_at; logic [31:0] wd, got, exp_rd; logic exp_e;
    for (int d = 0; d < 2; d++) begin
      nack = 0; a1 = -1; a2 = -1; set_at = -10; got = 32'h0; wd = $urandom;
      m_access(d, 1'b0, base_of(d) + 32'h20, MEM_SIZE_W, wd, 4'hF, exp_e, exp_rd);
      m_access(d, 1'b1, base_of(d) + 32'h20, MEM_SIZE_W, 32'h0, 4'h0, exp_e, exp_rd);
      req[d] = 1'b1; rw[d] = 1'b0; addr[d] = base_of(d) + 32'h20; size[d] = MEM_SIZE_W;
      wdata[d] = wd; wstrb[d] = 4'hF;
      @(posedge clk);
      for (int c = 1; c <= 14; c++) begin
        @(negedge clk);
        if (c == 1 || c == set_at + 1) req[d] = 1'b0;
        if (ack[d]) begin
          nack++;
          if (nack == 1) begin
            a1 = c; set_at = c;
            req[d] = 1'b1; rw[d] = 1'b1;
          end else begin
            a2 = c; got = rdata[d];
          end
        end
      end
      n_tests++; if (nack != 2) begin n_fail++; $display("FAIL b2b_acks d=%0d got %0d exp 2", d, nack); end
      n_tests++; if (a2 - a1 != 1 + wait_of(d)) begin n_fail++; $display("FAIL b2b_spacing d=%0d got %0d exp %0d", d, a2 - a1, 1 + wait_of(d)); end
      n_tests++; if (got !== exp_rd || got !== wd) begin n_fail++; $display("FAIL b2b_data d=%0d got %h exp %h", d, got, wd); end
    end
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] rd, exp_rd, wd; logic e, exp_e;
    for (int d = 0; d < 2; d++) begin
      m_access(d, 1'b1, base_of(d) + 32'(4*DEPTH), MEM_SIZE_W, 32'h0, 4'h0, exp_e, exp_rd);
      do_access(d, 1'b1, base_of(d) + 32'(4*DEPTH), MEM_SIZE_W, 32'h0, 4'h0, lat, rd, e);
      n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL oor_read_data d=%0d got %h exp 0", d, rd); end
      n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL oor_read_err d=%0d got %b exp 1", d, e); end
      wd = $urandom;
      m_access(d, 1'b0, base_of(d) + 32'(4*DEPTH), MEM_SIZE_W, wd, 4'hF, exp_e, exp_rd);
      do_access(d, 1'b0, base_of(d) + 32'(4*DEPTH), MEM_SIZE_W, wd, 4'hF, lat, rd, e);
      n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL oor_write_err d=%0d got %b exp 1", d, e); end
      m_access(d, 1'b1, base_of(d) + 32'(4*(DEPTH-1)), MEM_SIZE_W, 32'h0, 4'h0, exp_e, exp_rd);
      do_access(d, 1'b1, base_of(d) + 32'(4*(DEPTH-1)), MEM_SIZE_W, 32'h0, 4'h0, lat, rd, e);
      n_tests++; if (rd !== exp_rd || e !== 1'b0) begin n_fail++; $display("FAIL oor_last_word d=%0d got %h err %b exp %h err 0", d, rd, e, exp_rd); end
    end
  endtask

  task automatic test_misalign();
    int lat; logic [31:0] rd, exp_rd, wd; logic e, exp_e;
    wd = $urandom;
    m_access(0, 1'b0, 32'h13, MEM_SIZE_W, wd, 4'hF, exp_e, exp_rd);
    do_access(0, 1'b0, 32'h13, MEM_SIZE_W, wd, 4'hF, lat, rd, e);
    n_tests++; if (e !== CHK) begin n_fail++; $display("FAIL misalign_err got %b exp %b", e, CHK); end
    n_tests++; if (lat != 1) begin n_fail++; $display("FAIL misalign_lat got %0d exp 1", lat); end
    m_access(0, 1'b1, 32'h10, MEM_SIZE_W, 32'h0, 4'h0, exp_e, exp_rd);
    do_access(0, 1'b1, 32'h10, MEM_SIZE_W, 32'h0, 4'h0, lat, rd, e);
    n_tests++; if (rd !== exp_rd || (!CHK && rd !== wd)) begin n_fail++; $display("FAIL misalign_word got %h exp %h", rd, exp_rd); end
  endtask

  task automatic test_reset_mid();
    int nack, lat; logic [31:0] wd, rd, exp_rd, old; logic e, exp_e;
    // Write accepted, reset lands during WAIT: no ack, write stays committed.
    nack = 0; wd = $urandom;
    m_access(1, 1'b0, BASE1 + 32'h30, MEM_SIZE_W, wd, 4'hF, exp_e, exp_rd);
    req[1] = 1'b1; rw[1] = 1'b0; addr[1] = BASE1 + 32'h30; size[1] = MEM_SIZE_W;
    wdata[1] = wd; wstrb[1] = 4'hF;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) req[1] = 1'b0;
      if (c == 3) begin
        rst = 1'b0;
        n_tests++; if (busy[1] !== 1'b0 || ack[1] !== 1'b0 || err[1] !== 1'b0 || rdata[1] !== 32'h0) begin
          n_fail++; $display("FAIL rst_mid_outputs busy %b ack %b err %b data %h exp all 0", busy[1], ack[1], err[1], rdata[1]);
        end
      end
      if (ack[1]) nack++;
      if (c == 2) rst = 1'b1;
    end
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    n_tests++; if (nack != 0) begin n_fail++; $display("FAIL rst_mid_no_ack got %0d exp 0", nack); end
    m_access(1, 1'b1, BASE1 + 32'h30, MEM_SIZE_W, 32'h0, 4'h0, exp_e, exp_rd);
    do_access(1, 1'b1, BASE1 + 32'h30, MEM_SIZE_W, 32'h0, 4'h0, lat, rd, e);
    n_tests++; if (rd !== exp_rd || rd !== wd) begin n_fail++; $display("FAIL rst_mid_committed got %h exp %h", rd, wd); end
    // Request presented together with reset is ignored.
    old = model[0][16];
    rst = 1'b1; req[0] = 1'b1; rw[0] = 1'b0; addr[0] = 32'h40; size[0] = MEM_SIZE_W;
    wdata[0] = ~old; wstrb[0] = 4'hF;
    @(negedge clk);
    rst = 1'b0; req[0] = 1'b0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    n_tests++; if (ack[0] !== 1'b0) begin n_fail++; $display("FAIL rst_req_ack got %b exp 0", ack[0]); end
    m_access(0, 1'b1, 32'h40, MEM_SIZE_W, 32'h0, 4'h0, exp_e, exp_rd);
    do_access(0, 1'b1, 32'h40, MEM_SIZE_W, 32'h0, 4'h0, lat, rd, e);
    n_tests++; if (rd !== exp_rd || rd !== old) begin n_fail++; $display("FAIL rst_req_ignored got %h exp %h", rd, old); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; rw[d] = 1'b0; addr[d] = 32'h0; size[d] = 2'b00;
      wdata[d] = 32'h0; wstrb[d] = 4'h0; last_rd[d] = 32'h0;
    end
    test_reset();
    test_init();
    test_basic();
    test_wait_busy();
    test_back_to_back();
    test_out_of_range();
    test_misalign();
    test_random();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
